// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: opcode, funct and ALU encodings shared by the decode stage
package id_stage_pipe_pkg;
    localparam int ALU_OP_W  = 8;
    localparam int ALU_SEL_W = 3;
    typedef enum logic {RUN, SQUASH_WAIT} state_t;
    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_J = 6'h02, OPC_JAL = 6'h03, OPC_BEQ = 6'h04,
                           OPC_BNE = 6'h05, OPC_ADDIU = 6'h09, OPC_ORI = 6'h0D, OPC_LUI = 6'h0F,
                           OPC_LW = 6'h23, OPC_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [ALU_OP_W-1:0] ALU_NOP = 8'h00, ALU_OR = 8'h25, ALU_AND = 8'h24,
                                    ALU_SLL = 8'h7C, ALU_SRL = 8'h02, ALU_ADDU = 8'h21,
                                    ALU_SUBU = 8'h23, ALU_JAL = 8'h50, ALU_LW = 8'hE3,
                                    ALU_SW = 8'hEB;
    localparam logic [ALU_SEL_W-1:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2,
                                     SEL_ARITH = 3'd3, SEL_JUMP = 3'd4, SEL_MEM = 3'd5;
endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// id_stage_pipe_fwd_mux: per-port operand select, $0 then EX then MEM then register file
module id_stage_pipe_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int FWD_EN = 1
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata
);
    always_comb
        rdata = raddr == '0 ? '0 :
                FWD_EN == 0 ? rf_rdata :
                (ex_we && !ex_is_load && ex_waddr == raddr) ? ex_wdata :
                (mem_we && mem_waddr == raddr) ? mem_wdata : rf_rdata;
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage with forwarding, load-use stall, branch resolution and ID/EX register
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DELAY_SLOT = 1,
    parameter int FWD_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid_i,
    output logic                 if_ready_o,
    input  logic [31:0]          inst_i,
    input  logic [DATA_W-1:0]    inst_addr_i,
    output logic [ADDR_W-1:0]    rf_raddr1_o,
    output logic [ADDR_W-1:0]    rf_raddr2_o,
    input  logic [DATA_W-1:0]    rf_rdata1_i,
    input  logic [DATA_W-1:0]    rf_rdata2_i,
    input  logic                 ex_we_i,
    input  logic                 ex_is_load_i,
    input  logic [ADDR_W-1:0]    ex_waddr_i,
    input  logic [DATA_W-1:0]    ex_wdata_i,
    input  logic                 mem_we_i,
    input  logic [ADDR_W-1:0]    mem_waddr_i,
    input  logic [DATA_W-1:0]    mem_wdata_i,
    input  logic                 ex_ready_i,
    output logic                 id_valid_o,
    output logic [ALU_OP_W-1:0]  aluop_o,
    output logic [ALU_SEL_W-1:0] alusel_o,
    output logic [DATA_W-1:0]    reg1_o,
    output logic [DATA_W-1:0]    reg2_o,
    output logic [DATA_W-1:0]    store_data_o,
    output logic [DATA_W-1:0]    imm_o,
    output logic                 we_o,
    output logic [ADDR_W-1:0]    waddr_o,
    output logic                 link_o,
    output logic                 exc_ri_o,
    output logic                 branch_flag_o,
    output logic [DATA_W-1:0]    branch_target_o
);
    state_t state;
    logic [5:0] op, fn;
    logic [ADDR_W-1:0] rs, rt, rd, d_waddr;
    logic [15:0] imm;
    logic [DATA_W-1:0] op1, op2, pc4, sext, tgt, d_reg1, d_reg2, d_imm, d_store;
    logic [ALU_OP_W-1:0] d_op;
    logic [ALU_SEL_W-1:0] d_sel;
    logic re1, re2, d_we, d_link, d_ri, is_beq, is_bne, is_j, taken;
    logic ex_hit, mem_hit, load_hz, advance, accept;
    assign op = inst_i[31:26];
    assign fn = inst_i[5:0];
    assign rs = ADDR_W'(inst_i[25:21]);
    assign rt = ADDR_W'(inst_i[20:16]);
    assign rd = ADDR_W'(inst_i[15:11]);
    assign imm = inst_i[15:0];
    assign rf_raddr1_o = rs;
    assign rf_raddr2_o = rt;
    assign pc4 = inst_addr_i + DATA_W'(4);
    assign sext = {{(DATA_W-16){imm[15]}}, imm};
    id_stage_pipe_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_EN(FWD_EN)) u_fwd1 (
        .raddr(rs), .rf_rdata(rf_rdata1_i), .ex_we(ex_we_i), .ex_is_load(ex_is_load_i),
        .ex_waddr(ex_waddr_i), .ex_wdata(ex_wdata_i), .mem_we(mem_we_i),
        .mem_waddr(mem_waddr_i), .mem_wdata(mem_wdata_i), .rdata(op1));
    id_stage_pipe_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_EN(FWD_EN)) u_fwd2 (
        .raddr(rt), .rf_rdata(rf_rdata2_i), .ex_we(ex_we_i), .ex_is_load(ex_is_load_i),
        .ex_waddr(ex_waddr_i), .ex_wdata(ex_wdata_i), .mem_we(mem_we_i),
        .mem_waddr(mem_waddr_i), .mem_wdata(mem_wdata_i), .rdata(op2));
    always_comb begin
        re1 = 1'b0; re2 = 1'b0; d_we = 1'b0; d_waddr = '0; d_link = 1'b0; d_ri = 1'b0;
        d_op = ALU_NOP; d_sel = SEL_NOP; d_reg1 = '0; d_reg2 = '0; d_imm = '0; d_store = '0;
        is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0;
        case (op)
            OPC_SPECIAL: begin
                case (fn)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR: begin
                        re1 = 1'b1; re2 = 1'b1; d_we = 1'b1; d_waddr = rd; d_reg1 = op1; d_reg2 = op2;
                        d_op = fn == FN_ADDU ? ALU_ADDU : fn == FN_SUBU ? ALU_SUBU : fn == FN_AND ? ALU_AND : ALU_OR;
                        d_sel = (fn == FN_AND || fn == FN_OR) ? SEL_LOGIC : SEL_ARITH;
                    end
                    FN_SLL, FN_SRL: begin
                        re2 = 1'b1; d_we = 1'b1; d_waddr = rd; d_reg1 = DATA_W'(inst_i[10:6]); d_reg2 = op2;
                        d_op = fn == FN_SLL ? ALU_SLL : ALU_SRL; d_sel = SEL_SHIFT;
                    end
                    default: d_ri = 1'b1;
                endcase
            end
            OPC_ORI: begin
                re1 = 1'b1; d_we = 1'b1; d_waddr = rt; d_reg1 = op1; d_reg2 = DATA_W'(imm);
                d_op = ALU_OR; d_sel = SEL_LOGIC;
            end
            OPC_ADDIU: begin
                re1 = 1'b1; d_we = 1'b1; d_waddr = rt; d_reg1 = op1; d_reg2 = sext;
                d_op = ALU_ADDU; d_sel = SEL_ARITH;
            end
            OPC_LUI: begin
                d_we = 1'b1; d_waddr = rt; d_reg2 = {imm, {(DATA_W-16){1'b0}}};
                d_op = ALU_OR; d_sel = SEL_LOGIC;
            end
            OPC_BEQ: begin re1 = 1'b1; re2 = 1'b1; is_beq = 1'b1; end
            OPC_BNE: begin re1 = 1'b1; re2 = 1'b1; is_bne = 1'b1; end
            OPC_J: is_j = 1'b1;
            OPC_JAL: begin
                is_j = 1'b1; d_we = 1'b1; d_waddr = ADDR_W'(31); d_link = 1'b1;
                d_reg1 = inst_addr_i + DATA_W'(8); d_op = ALU_JAL; d_sel = SEL_JUMP;
            end
            OPC_LW: begin
                re1 = 1'b1; d_we = 1'b1; d_waddr = rt; d_reg1 = op1; d_imm = sext;
                d_op = ALU_LW; d_sel = SEL_MEM;
            end
            OPC_SW: begin
                re1 = 1'b1; re2 = 1'b1; d_reg1 = op1; d_reg2 = op2; d_store = op2; d_imm = sext;
                d_op = ALU_SW; d_sel = SEL_MEM;
            end
            default: d_ri = 1'b1;
        endcase
    end
    assign taken = is_j || (is_beq && op1 == op2) || (is_bne && op1 != op2);
    assign tgt = !taken ? '0 : is_j ? {pc4[DATA_W-1:28], inst_i[25:0], 2'b00} : pc4 + (sext << 2);
    // only registers this instruction really reads can create a hazard
    assign ex_hit = ex_we_i && ((re1 && |rs && ex_waddr_i == rs) || (re2 && |rt && ex_waddr_i == rt));
    assign mem_hit = mem_we_i && ((re1 && |rs && mem_waddr_i == rs) || (re2 && |rt && mem_waddr_i == rt));
    assign load_hz = (ex_is_load_i && ex_hit) || (FWD_EN == 0 && (ex_hit || mem_hit));
    assign advance = !id_valid_o || ex_ready_i;
    assign if_ready_o = state == SQUASH_WAIT || (advance && !load_hz);
    assign accept = if_valid_i && state == RUN && advance && !load_hz;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            branch_flag_o <= 1'b0;
            {id_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, store_data_o, imm_o, we_o, waddr_o,
             link_o, exc_ri_o, branch_target_o} <= '0;
        end else begin
            branch_flag_o <= accept && taken;
            state <= (accept && taken && DELAY_SLOT == 0) ? SQUASH_WAIT :
                     (state == SQUASH_WAIT && if_valid_i) ? RUN : state;
            if (accept)
                {id_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, store_data_o, imm_o, we_o, waddr_o,
                 link_o, exc_ri_o, branch_target_o} <= {1'b1, d_op, d_sel, d_reg1, d_reg2, d_store,
                 d_imm, d_we, d_waddr, d_link, d_ri, tgt};
            else if (advance)
                {id_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, store_data_o, imm_o, we_o, waddr_o,
                 link_o, exc_ri_o, branch_target_o} <= '0;
        end
    end
endmodule
